// File: rtl/fc_result_argmax_pkg.sv
// Shared widths, FSM encoding and constants for the FC3 result argmax reader.
package fc_result_argmax_pkg;

    localparam int SCORE_W     = 16;
    localparam int NUM_CLASSES = 10;
    localparam int DIGIT_W     = 4;

    localparam logic [SCORE_W-1:0] MOST_NEG = {1'b1, {(SCORE_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        SCAN    = 3'd2,
        FINISH  = 3'd3,
        HOLD    = 3'd4
    } state_t;

    // Widening by one bit keeps best - second from overflowing (e.g. 7FFF - 8000).
    function automatic logic [SCORE_W:0] score_diff(input logic [SCORE_W-1:0] a,
                                                     input logic [SCORE_W-1:0] b);
        return {a[SCORE_W-1], a} - {b[SCORE_W-1], b};
    endfunction

endpackage

// File: rtl/fc_result_argmax_score_compare.sv
// Signed comparison of one scanned lane against the running best and runner-up.
module score_compare #(
    parameter int W = 16
) (
    input  logic [W-1:0] lane,
    input  logic [W-1:0] best,
    input  logic [W-1:0] second,
    output logic         gt_best,
    output logic         gt_second
);

    assign gt_best   = $signed(lane) > $signed(best);
    assign gt_second = $signed(lane) > $signed(second);

endmodule

// File: rtl/fc_result_argmax.sv
// Captures the FC3 class scores on a done edge, scans one lane per cycle and
// reports the winning digit, its score and the margin over the runner-up.
module fc_result_argmax
    import fc_result_argmax_pkg::*;
(
    input  logic                           clk,
    input  logic                           iRst_n,
    input  logic                           ena,
    input  logic                           start,
    input  logic [NUM_CLASSES*SCORE_W-1:0] data_from_fc,
    output logic                           busy,
    output logic                           done,
    output logic [DIGIT_W-1:0]             digit,
    output logic [SCORE_W-1:0]             max_score,
    output logic [SCORE_W:0]               margin
);

    state_t state, state_n;

    logic                                  start_d;
    logic                                  start_edge;
    logic [NUM_CLASSES-1:0][SCORE_W-1:0]   scores;
    logic [SCORE_W-1:0]                    best;
    logic [SCORE_W-1:0]                    second;
    logic [DIGIT_W-1:0]                    best_idx;
    logic [DIGIT_W-1:0]                    idx;
    logic [SCORE_W-1:0]                    lane;
    logic                                  gt_best;
    logic                                  gt_second;

    assign start_edge = start & ~start_d;
    assign lane       = scores[idx];

    score_compare #(.W(SCORE_W)) u_cmp (
        .lane      (lane),
        .best      (best),
        .second    (second),
        .gt_best   (gt_best),
        .gt_second (gt_second)
    );

    // start_d follows start even while disabled, so a level held across ena is no edge.
    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) start_d <= 1'b0;
        else         start_d <= start;
    end

    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_edge) state_n = CAPTURE;
            CAPTURE: state_n = SCAN;
            SCAN:    if (idx == DIGIT_W'(NUM_CLASSES-1)) state_n = FINISH;
            FINISH:  state_n = HOLD;
            HOLD:    if (start_edge) state_n = CAPTURE;
            default: state_n = IDLE;
        endcase
        if (!ena) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            scores    <= '0;
            best      <= '0;
            second    <= '0;
            best_idx  <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            digit     <= '0;
            max_score <= '0;
            margin    <= '0;
        end else if (!ena) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                CAPTURE: begin
                    scores   <= data_from_fc;
                    best     <= data_from_fc[SCORE_W-1:0];
                    best_idx <= '0;
                    second   <= MOST_NEG;
                    idx      <= DIGIT_W'(1);
                    busy     <= 1'b1;
                    done     <= 1'b0;
                end
                SCAN: begin
                    // Strict compare: equal scores keep the earlier (lower) index.
                    if (gt_best) begin
                        second   <= best;
                        best     <= lane;
                        best_idx <= idx;
                    end else if (gt_second) begin
                        second <= lane;
                    end
                    idx <= idx + DIGIT_W'(1);
                end
                FINISH: begin
                    digit     <= best_idx;
                    max_score <= best;
                    margin    <= score_diff(best, second);
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
